// File: rtl/sync_fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_rd_stream: drains a registered-read FIFO into a valid/ready    |
// | stream via a 2-entry buffer. SYNC_FIFO_RD_STREAM_STATS_EN adds counters. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sync_fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             fifo_r_en,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
  ,
  output logic [15:0]      rd_count,
  output logic [15:0]      stall_count
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           state;
  logic             inflight;
  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;

  logic             pop;
  logic             capture;
  logic [1:0]       occ;
  logic [1:0]       occ_nxt;
  logic             head_nxt;
  logic [WIDTH-1:0] data_nxt;

  assign occ      = state;
  assign pop      = m_valid & m_ready;
  assign capture  = inflight;

  // Reserve a slot for every word already requested; a pop frees one this cycle.
  assign fifo_r_en = !rst && !flush && !fifo_empty &&
                     (((occ + {1'b0, inflight}) < 2'd2) || pop);

  assign occ_nxt  = occ + {1'b0, capture} - {1'b0, pop};
  assign head_nxt = head ^ pop;
  // The new head may be the slot being written on this same edge.
  assign data_nxt = (capture && (head_nxt == tail)) ? fifo_rdata : mem[head_nxt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_EMPTY;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else if (flush) begin
      state    <= S_EMPTY;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      inflight <= fifo_r_en;
      if (capture) begin
        mem[tail] <= fifo_rdata;
        tail      <= ~tail;
      end
      head    <= head_nxt;
      m_valid <= (occ_nxt != 2'd0);
      m_data  <= data_nxt;
      case (state)
        S_EMPTY: if (capture) state <= S_ONE;
        S_ONE: begin
          if (capture && !pop)      state <= S_TWO;
          else if (pop && !capture) state <= S_EMPTY;
        end
        S_TWO:   if (pop) state <= S_ONE;
        default: state <= S_EMPTY;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(!flush && capture && !pop && (state == S_TWO)));

`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count    <= '0;
      stall_count <= '0;
    end else begin
      if (pop && (rd_count != 16'hFFFF))
        rd_count <= rd_count + 16'd1;
      if (m_valid && !m_ready && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_rd_stream.sv
`default_nettype none
// Bench for sync_fifo_rd_stream: behavioural FIFO plus in-order scoreboard.
module tb_sync_fifo_rd_stream;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             fifo_r_en;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             fifo_empty = 1'b1;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready = 1'b0;
`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
  logic [15:0]      rd_count;
  logic [15:0]      stall_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         n_ren = 0;
  int         n_pop = 0;
  int         pop_cyc[$];
  int         ren_cyc[$];
  logic [7:0] last_pop = '0;
  bit         hold_pend = 1'b0;
  logic [7:0] hold_data = '0;
  int         mdl_rd = 0;
  int         mdl_stall = 0;

  sync_fifo_rd_stream #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_r_en  (fifo_r_en),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
    ,
    .rd_count   (rd_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // One clock: observe at negedge, then model the FIFO read just after posedge.
  task automatic step();
    bit         ren_s;
    bit         flush_s;
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    ren_s   = fifo_r_en;
    flush_s = flush;
    if (!rst) begin
      if (fifo_empty) begin
        checks++;
        if (fifo_r_en !== 1'b0) begin
          failures++;
          $display("FAIL r_en_while_empty cyc=%0d got=%b want=0", cyc, fifo_r_en);
        end
      end
      if (hold_pend) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== hold_data) begin
          failures++;
          $display("FAIL hold_stable cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                   cyc, m_valid, m_data, hold_data);
        end
      end
      if (m_valid === 1'b1 && m_ready) begin
        n_pop++;
        pop_cyc.push_back(cyc);
        last_pop = m_data;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_data cyc=%0d got=%h want=none(duplicate/extra)", cyc, m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            failures++;
            $display("FAIL pop_data cyc=%0d got=%h want=%h", cyc, m_data, e);
          end
        end
        if (mdl_rd < 65535) mdl_rd++;
      end
      if (m_valid === 1'b1 && !m_ready && mdl_stall < 65535) mdl_stall++;
      if (ren_s) begin
        n_ren++;
        ren_cyc.push_back(cyc);
      end
      hold_pend = (m_valid === 1'b1) && !m_ready && !flush;
      hold_data = m_data;
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      if (flush_s) exp_q.delete();
      if (ren_s && fq.size() > 0) begin
        fifo_rdata = fq.pop_front();
        exp_q.push_back(fifo_rdata);
      end
      fifo_empty = (fq.size() == 0);
      checks++;
      if (exp_q.size() > 2) begin
        failures++;
        $display("FAIL outstanding_words cyc=%0d got=%0d want<=2", cyc, exp_q.size());
      end
    end
  endtask

  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    m_ready = 1'b0;
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    hold_pend = 1'b0;
    mdl_rd = 0;
    mdl_stall = 0;
    n_ren = 0;
    n_pop = 0;
    pop_cyc.delete();
    ren_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 10; i++) begin
      if (m_valid === 1'b1) break;
      step();
    end
    checks++;
    if (m_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout got m_valid=%b want=1", name, m_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_r_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h ren=%b want 0/00/0", m_valid, m_data, fifo_r_en);
    end
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i + 8'h40));
    repeat (6) step();
    checks++;
    if (m_valid !== 1'b1 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL reset_prefill got v=%b outstanding=%0d want v=1 outstanding=2",
               m_valid, exp_q.size());
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_r_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got v=%b d=%h ren=%b want 0/00/0", m_valid, m_data, fifo_r_en);
    end
    do_reset();
    repeat (3) step();
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_r_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got v=%b d=%h ren=%b want 0/00/0", m_valid, m_data, fifo_r_en);
    end
`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
    checks++;
    if (rd_count !== 16'd0 || stall_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_stats got rd=%0d stall=%0d want 0/0", rd_count, stall_count);
    end
`endif
  endtask

  task automatic test_streaming();
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (14) step();
    checks++;
    if (n_ren != 8 || n_pop != 8 || last_pop !== 8'h08) begin
      failures++;
      $display("FAIL stream_counts got ren=%0d pops=%0d last=%h want 8/8/08", n_ren, n_pop, last_pop);
    end else begin
      // r_en sampled before edge k, data registered by FIFO at k, captured at k+1.
      checks++;
      if (pop_cyc[0] != ren_cyc[0] + 2 || pop_cyc[7] != pop_cyc[0] + 7 ||
          ren_cyc[7] != ren_cyc[0] + 7) begin
        failures++;
        $display("FAIL stream_timing got first_ren=%0d first_pop=%0d last_pop=%0d want pops at first_ren+2..+9",
                 ren_cyc[0], pop_cyc[0], pop_cyc[7]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    wait_valid("bp");
    repeat (5) step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h01 || fifo_r_en !== 1'b0 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL bp_full got v=%b d=%h ren=%b outstanding=%0d want 1/01/0/2",
               m_valid, m_data, fifo_r_en, exp_q.size());
    end
    m_ready = 1'b1;
    repeat (10) step();
    checks++;
    if (n_pop != 4 || last_pop !== 8'h04 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain got pops=%0d last=%h left=%0d want 4/04/0", n_pop, last_pop, exp_q.size());
    end
`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
    checks++;
    if (stall_count !== 16'd5 || rd_count !== 16'd4) begin
      failures++;
      $display("FAIL bp_stats got stall=%0d rd=%0d want 5/4", stall_count, rd_count);
    end
`endif
  endtask

  task automatic test_empty_boundary();
    do_reset();
    m_ready = 1'b1;
    push(8'hA5);
    repeat (6) step();
    checks++;
    if (n_ren != 1 || n_pop != 1 || last_pop !== 8'hA5 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_boundary got ren=%0d pops=%0d last=%h v=%b want 1/1/a5/0",
               n_ren, n_pop, last_pop, m_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    m_ready = 1'b0;
    push(8'hB1);
    push(8'hB2);
    push(8'hB3);
    wait_valid("flush");
    checks++;
    if (exp_q.size() != 2) begin
      failures++;
      $display("FAIL flush_pre got outstanding=%0d want 2", exp_q.size());
    end
    flush = 1'b1;
    #1;
    checks++;
    if (fifo_r_en !== 1'b0) begin
      failures++;
      $display("FAIL flush_ren got=%b want=0", fifo_r_en);
    end
    step();
    flush = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL flush_drop got v=%b outstanding=%0d want 0/0", m_valid, exp_q.size());
    end
    m_ready = 1'b1;
    repeat (6) step();
    checks++;
    if (n_pop != 1 || last_pop !== 8'hB3) begin
      failures++;
      $display("FAIL flush_next got pops=%0d last=%h want 1/b3", n_pop, last_pop);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (fq.size() < 6 && ($urandom % 3) != 0) push(8'($urandom));
      m_ready = (($urandom % 4) != 0);
      flush   = (($urandom % 40) == 0);
      step();
    end
    flush = 1'b0;
    m_ready = 1'b1;
    repeat (20) step();
    checks++;
    if (fq.size() != 0 || exp_q.size() != 0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL random_drain got fifo=%0d outstanding=%0d v=%b want 0/0/0",
               fq.size(), exp_q.size(), m_valid);
    end
`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
    checks++;
    if (rd_count !== 16'(mdl_rd) || stall_count !== 16'(mdl_stall)) begin
      failures++;
      $display("FAIL random_stats got rd=%0d stall=%0d want %0d/%0d",
               rd_count, stall_count, mdl_rd, mdl_stall);
    end
`endif
  endtask

`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
  task automatic test_stats_saturation();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 70010; i++) begin
      if (fq.size() < 4) push(8'(i));
      step();
    end
    checks++;
    if (rd_count !== 16'hFFFF || stall_count !== 16'h0000 || n_pop < 70000) begin
      failures++;
      $display("FAIL stats_saturate got rd=%h stall=%h pops=%0d want ffff/0000/>=70000",
               rd_count, stall_count, n_pop);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_random();
`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
    test_stats_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
